// File: rtl/rr_vn_arb_p.sv
// rr_vn_arb_p: registered round-robin arbiter over all NUM_VN x NUM_VC injector request lines.
// Optional packet lock (grant held until tail_i) is compiled in with `define RR_VN_ARB_LOCK_EN.
module rr_vn_arb_p #(
    parameter int NUM_VC = 1,
    parameter int NUM_VN = 3,
    localparam int N = NUM_VC * NUM_VN,
    localparam int B = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         ack_i,
    input  logic         tail_i,
    output logic [N-1:0] gnt_o,
    output logic [B-1:0] gnt_id_o,
    output logic         gnt_valid_o,
    output logic [B-1:0] ptr_o
);

`ifdef RR_VN_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
`endif

    localparam logic [B:0]   N_EXT  = (B+1)'(N);
    localparam logic [B-1:0] ID_MAX = B'(N - 1);

    state_t       state_q;
    logic [N-1:0] gnt_q;
    logic [B-1:0] gnt_id_q;
    logic         gnt_valid_q;
    logic [B-1:0] ptr_q;

    logic         any_req;
    logic         held;
    logic         release_w;
    logic         withdraw_w;
    logic [B-1:0] ptr_adv;
    logic [B-1:0] arb_ptr;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0] rot;
    logic [B-1:0] enc;
    logic [B:0]   win_sum;
    logic [B-1:0] win_id;
    logic [N-1:0] win_oh;

    assign any_req = |req_i;
    assign held    = |(gnt_q & req_i);
    assign ptr_adv = (gnt_id_q == ID_MAX) ? '0 : gnt_id_q + 1'b1;

`ifdef RR_VN_ARB_LOCK_EN
    logic lock_w;
    assign release_w = gnt_valid_q & ack_i & tail_i;
    assign lock_w    = (state_q == ST_GRANT) & ack_i & ~tail_i & held;
`else
    logic unused_tail;
    assign unused_tail = tail_i;
    assign release_w   = gnt_valid_q & ack_i;
`endif

    // Release and withdrawal are exclusive; release wins if the bit also drops.
    assign withdraw_w = gnt_valid_q & ~held & ~release_w;

    // Back-to-back regrant must already see the advanced pointer.
    assign arb_ptr = release_w ? ptr_adv : ptr_q;

    always_comb begin
        req_dbl = {req_i, req_i};
        rot     = N'(req_dbl >> arb_ptr);
        enc     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = B'(i);
            end
        end
        win_sum = {1'b0, enc} + {1'b0, arb_ptr};
        win_id  = (win_sum >= N_EXT) ? B'(win_sum - N_EXT) : B'(win_sum);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_win_oh
        assign win_oh[gi] = (win_id == B'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            if (release_w) begin
                ptr_q <= ptr_adv;
            end
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q     <= ST_GRANT;
                        gnt_q       <= win_oh;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (release_w || withdraw_w) begin
                        if (any_req) begin
                            state_q     <= ST_GRANT;
                            gnt_q       <= win_oh;
                            gnt_id_q    <= win_id;
                            gnt_valid_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            gnt_q       <= '0;
                            gnt_id_q    <= '0;
                            gnt_valid_q <= 1'b0;
                        end
                    end
`ifdef RR_VN_ARB_LOCK_EN
                    else if (lock_w) begin
                        state_q <= ST_LOCK;
                    end
`endif
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_valid_q;
    assign ptr_o       = ptr_q;

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid_q |-> $onehot(gnt_q));
    a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !gnt_valid_q |-> (gnt_q == '0));
`endif

endmodule

// File: tb/tb_rr_vn_arb_p.sv
// Bench for rr_vn_arb_p: directed scenarios plus random traffic against a search-based round-robin model.
module tb_rr_vn_arb_p;
    localparam int N = 3;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic         ack_i;
    logic         tail_i;
    logic [N-1:0] gnt_o;
    logic [B-1:0] gnt_id_o;
    logic         gnt_valid_o;
    logic [B-1:0] ptr_o;

    int errs   = 0;
    int checks = 0;
    int m_valid, m_id, m_ptr;

    rr_vn_arb_p #(.NUM_VC(1), .NUM_VN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .tail_i     (tail_i),
        .gnt_o      (gnt_o),
        .gnt_id_o   (gnt_id_o),
        .gnt_valid_o(gnt_valid_o),
        .ptr_o      (ptr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester found scanning upward from p, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] s;
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            s = r >> idx;
            if (s[0]) return idx;
        end
        return 0;
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q, input logic a, input logic t);
        logic rel;
        logic [N-1:0] s;
        if (!r) begin
            m_valid = 0; m_id = 0; m_ptr = 0;
        end else if (m_valid == 0) begin
            if (q != 0) begin
                m_valid = 1;
                m_id = pick(q, m_ptr);
            end
        end else begin
            rel = a;
`ifdef RR_VN_ARB_LOCK_EN
            rel = a && t;
`endif
            s = q >> m_id;
            if (rel) begin
                m_ptr = (m_id + 1) % N;
                if (q != 0) m_id = pick(q, m_ptr);
                else m_valid = 0;
            end else if (!s[0]) begin
                if (q != 0) m_id = pick(q, m_ptr);
                else m_valid = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q, input logic a, input logic t,
                        input string tag);
        rst_n = r; req_i = q; ack_i = a; tail_i = t;
        model_step(r, q, a, t);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, gnt_valid_o, m_valid);
        chk({tag, ".ptr"}, ptr_o, m_ptr);
        if (m_valid != 0) begin
            chk({tag, ".id"}, gnt_id_o, m_id);
            chk({tag, ".gnt"}, gnt_o, 1 << m_id);
        end else if (!r) begin
            chk({tag, ".gnt0"}, gnt_o, 0);
            chk({tag, ".id0"}, gnt_id_o, 0);
        end
        $display("%s rst_n=%0b req=%03b ack=%0b tail=%0b -> valid=%0b gnt=%03b id=%0d ptr=%0d",
                 tag, r, q, a, t, gnt_valid_o, gnt_o, gnt_id_o, ptr_o);
    endtask

    initial begin
        logic [N-1:0] q;
        logic r, a, t;
        int exp_ids[5] = '{0, 1, 2, 0, 1};

        rst_n = 1'b0; req_i = '0; ack_i = 1'b0; tail_i = 1'b0;
        step(0, 3'b000, 0, 0, "rst");

        // Full request set, ack every cycle: per-flit rotation 0,1,2,0,1.
        for (int i = 0; i < 5; i++) begin
            step(1, 3'b111, 1, 1, "rr");
            chk("rr.seq", gnt_id_o, exp_ids[i]);
            chk("rr.v", gnt_valid_o, 1);
        end

        // Single requester at top index, pointer wraps to 0.
        step(0, 3'b000, 0, 0, "rst2");
        step(1, 3'b100, 0, 0, "top");
        chk("top.gnt", gnt_o, 3'b100);
        step(1, 3'b100, 1, 1, "top_ack");
        chk("top.ptr", ptr_o, 0);
        step(1, 3'b000, 0, 0, "top_drop");
        chk("top.idle", gnt_valid_o, 0);

        // Pointer at 2 with requests 0 and 1: wrap search picks 0.
        step(0, 3'b000, 0, 0, "rst3");
        step(1, 3'b010, 0, 0, "p2a");
        step(1, 3'b000, 1, 1, "p2b");
        chk("p2.ptr", ptr_o, 2);
        step(1, 3'b011, 0, 0, "p2c");
        chk("p2.win", gnt_id_o, 0);
        step(1, 3'b011, 1, 1, "p2d");
        chk("p2.ptr1", ptr_o, 1);

        // Withdrawal of granted requester moves grant, pointer untouched.
        step(0, 3'b000, 0, 0, "rst4");
        step(1, 3'b010, 0, 0, "wd1");
        step(1, 3'b100, 0, 0, "wd2");
        chk("wd.id", gnt_id_o, 2);
        chk("wd.ptr", ptr_o, 0);

        // Reset beats an ack on a live grant.
        step(1, 3'b111, 0, 0, "rg1");
        step(0, 3'b111, 1, 1, "rg2");
        chk("rg.valid", gnt_valid_o, 0);
        chk("rg.ptr", ptr_o, 0);

`ifdef RR_VN_ARB_LOCK_EN
        step(1, 3'b011, 0, 0, "lk0");
        step(1, 3'b011, 1, 0, "lk1");
        chk("lk1.id", gnt_id_o, 0);
        chk("lk1.ptr", ptr_o, 0);
        step(1, 3'b011, 1, 0, "lk2");
        chk("lk2.id", gnt_id_o, 0);
        chk("lk2.ptr", ptr_o, 0);
        step(1, 3'b011, 1, 1, "lk3");
        chk("lk3.id", gnt_id_o, 1);
        chk("lk3.ptr", ptr_o, 1);
`endif

        // Random traffic with sticky requests and occasional reset.
        q = 3'b000;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 2) == 0) q = N'($urandom_range(0, 7));
            a = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            step(r, q, a, t, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
